// File: rtl/para_pkg.sv
// Shared datatype and address-generator types for the tensor write-back path.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package params;

    // Element datatype carried by the PE results.
    typedef enum logic [1:0] {
        INT8 = 2'd0,
        FP16 = 2'd1,
        FP32 = 2'd2,
        BF16 = 2'd3
    } datatype_t;

    // Address-generator configuration handed to the write-back engine.
    typedef struct packed {
        datatype_t datatype;
    } addrgen_t;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

endpackage

// File: rtl/axi_wb_beat_sel.sv
// Picks the W beat payload out of the flat PE result vector for a given beat index.
// Latency: combinational.
// Backpressure: none; the caller holds beat and regfiles stable while stalled.
// Ports: regfiles (flat PE results), special (packed low-half mode), beat (beat index),
//        wdata (selected beat payload).
module axi_wb_beat_sel #(
    parameter int DATA_WIDTH = 256,
    parameter int PE_ROWS    = 8,
    parameter int PE_COLS    = 8,
    parameter int PE_WORD    = 128,
    parameter int IDX_W      = 6
) (
    input  logic [PE_ROWS*PE_COLS*PE_WORD-1:0] regfiles,
    input  logic                               special,
    input  logic [IDX_W-1:0]                   beat,
    output logic [DATA_WIDTH-1:0]              wdata
);

    localparam int HALF  = PE_WORD / 2;
    // Number of PE low halves packed into one beat in special mode.
    localparam int LANES = DATA_WIDTH / HALF;

    always_comb begin
        wdata = '0;
        if (special) begin
            for (int j = 0; j < LANES; j++) begin
                wdata[j*HALF +: HALF] = regfiles[(int'(beat) * LANES + j) * PE_WORD +: HALF];
            end
        end else begin
            wdata = regfiles[int'(beat) * DATA_WIDTH +: DATA_WIDTH];
        end
    end

endmodule

// File: rtl/axi_tensor_wb.sv
// Streams the PE result array to memory as a sequence of AXI4 INCR write bursts.
// Latency: AW one cycle after start, first W one cycle after AW handshake, done one cycle after final B.
// Backpressure: AW/W/B stall in place on ready/valid low; address and data held stable while stalled.
// Ports: clk/rst, wr_enb start pulse, mixed + addr_type select packing mode, base_addr start address,
//        regfiles PE results, AXI AW/W/B channels, busy/done/err status.
module axi_tensor_wb import params::*; #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 256,
    parameter int PE_ROWS    = 8,
    parameter int PE_COLS    = 8,
    parameter int PE_WORD    = 128,
    parameter int MAX_BURST  = 16
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               wr_enb,
    input  logic                               mixed,
    input  addrgen_t                           addr_type,
    input  logic [ADDR_WIDTH-1:0]              base_addr,
    input  logic [PE_ROWS*PE_COLS*PE_WORD-1:0] regfiles,
    output logic                               axi_awvalid,
    input  logic                               axi_awready,
    output logic [ADDR_WIDTH-1:0]              axi_awaddr,
    output logic [7:0]                         axi_awlen,
    output logic [2:0]                         axi_awsize,
    output logic [1:0]                         axi_awburst,
    output logic                               axi_wvalid,
    input  logic                               axi_wready,
    output logic [DATA_WIDTH-1:0]              axi_wdata,
    output logic [DATA_WIDTH/8-1:0]            axi_wstrb,
    output logic                               axi_wlast,
    input  logic                               axi_bvalid,
    output logic                               axi_bready,
    input  logic [1:0]                         axi_bresp,
    output logic                               busy,
    output logic                               done,
    output logic                               err
);

    localparam int TOTAL_BITS = PE_ROWS * PE_COLS * PE_WORD;
    localparam int T_NORM     = TOTAL_BITS / DATA_WIDTH;
    localparam int T_SPEC     = T_NORM / 2;
    localparam int CNT_W      = $clog2(T_NORM + 1);
    localparam int BYTES      = DATA_WIDTH / 8;

    typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;

    state_t                  state, state_nxt;
    logic [CNT_W-1:0]        beat_idx;     // beats accepted on W since start
    logic [CNT_W-1:0]        total;
    logic [8:0]              burst_left;   // beats still to send in the current burst
    logic [ADDR_WIDTH-1:0]   base_q;
    logic                    special_q;
    logic                    done_q;
    logic                    err_q;
    logic                    start, aw_hs, w_hs, b_hs, all_sent;
    int                      remaining;
    int                      burst_len;

    assign total    = special_q ? CNT_W'(T_SPEC) : CNT_W'(T_NORM);
    assign start    = (state == IDLE) && wr_enb;
    assign aw_hs    = axi_awvalid && axi_awready;
    assign w_hs     = axi_wvalid && axi_wready;
    assign b_hs     = axi_bready && axi_bvalid;
    assign all_sent = (beat_idx == total);

    // beat_idx only moves in DATA, so the burst size is stable across an AW stall.
    always_comb begin
        remaining = int'(total) - int'(beat_idx);
        burst_len = (remaining > MAX_BURST) ? MAX_BURST : remaining;
    end

    assign axi_awaddr  = base_q + ADDR_WIDTH'(beat_idx) * ADDR_WIDTH'(BYTES);
    assign axi_awlen   = 8'(burst_len - 1);
    assign axi_awsize  = 3'($clog2(BYTES));
    assign axi_awburst = AXI_BURST_INCR;
    assign axi_wstrb   = '1;
    assign done        = done_q;
    assign err         = err_q;

    axi_wb_beat_sel #(
        .DATA_WIDTH (DATA_WIDTH),
        .PE_ROWS    (PE_ROWS),
        .PE_COLS    (PE_COLS),
        .PE_WORD    (PE_WORD),
        .IDX_W      (CNT_W)
    ) u_beat_sel (
        .regfiles (regfiles),
        .special  (special_q),
        .beat     (beat_idx),
        .wdata    (axi_wdata)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (wr_enb) state_nxt = ADDR;
            ADDR:    if (aw_hs) state_nxt = DATA;
            DATA:    if (w_hs && axi_wlast) state_nxt = RESP;
            RESP:    if (b_hs) state_nxt = all_sent ? IDLE : ADDR;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        axi_awvalid = (state == ADDR);
        axi_wvalid  = (state == DATA);
        axi_bready  = (state == RESP);
        busy        = (state != IDLE);
        axi_wlast   = (state == DATA) && (burst_left == 9'd1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beat_idx   <= '0;
            burst_left <= '0;
            base_q     <= '0;
            special_q  <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (start) begin
                beat_idx  <= '0;
                base_q    <= base_addr;
                // FP16 without mixed precision only keeps the low half of each PE word.
                special_q <= !mixed && (addr_type.datatype == FP16);
                err_q     <= 1'b0;
            end
            if (aw_hs) begin
                burst_left <= 9'(burst_len);
            end
            if (w_hs) begin
                beat_idx   <= beat_idx + CNT_W'(1);
                burst_left <= burst_left - 9'd1;
            end
            if (b_hs) begin
                if (axi_bresp != AXI_RESP_OKAY) err_q <= 1'b1;
                if (all_sent) done_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_axi_tensor_wb.sv
// Self-checking bench for axi_tensor_wb: table of transfer scenarios plus random transfers,
// each driven through a randomly stalling AXI slave and compared beat-by-beat to a reference model.
// Ports: none (top-level bench).
module tb_axi_tensor_wb;
    import params::*;

    localparam int NB  = 8 * 8 * 128;   // flat regfiles width
    localparam int DW  = 256;
    localparam int MB  = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             wr_enb;
    logic             mixed;
    addrgen_t         addr_type;
    logic [31:0]      base_addr;
    logic [NB-1:0]    regfiles;
    logic             awvalid, awready;
    logic [31:0]      awaddr;
    logic [7:0]       awlen;
    logic [2:0]       awsize;
    logic [1:0]       awburst;
    logic             wvalid, wready;
    logic [DW-1:0]    wdata;
    logic [DW/8-1:0]  wstrb;
    logic             wlast;
    logic             bvalid, bready;
    logic [1:0]       bresp;
    logic             busy, done, err;

    int nchecks = 0;
    int nerr    = 0;

    axi_tensor_wb #(
        .ADDR_WIDTH (32), .DATA_WIDTH (DW), .PE_ROWS (8), .PE_COLS (8),
        .PE_WORD (128), .MAX_BURST (MB)
    ) dut (
        .clk (clk), .rst (rst), .wr_enb (wr_enb), .mixed (mixed), .addr_type (addr_type),
        .base_addr (base_addr), .regfiles (regfiles),
        .axi_awvalid (awvalid), .axi_awready (awready), .axi_awaddr (awaddr), .axi_awlen (awlen),
        .axi_awsize (awsize), .axi_awburst (awburst),
        .axi_wvalid (wvalid), .axi_wready (wready), .axi_wdata (wdata), .axi_wstrb (wstrb),
        .axi_wlast (wlast), .axi_bvalid (bvalid), .axi_bready (bready), .axi_bresp (bresp),
        .busy (busy), .done (done), .err (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          mixed;
        datatype_t   dt;
        logic [31:0] base;
        int          stall;       // percent of cycles a ready/valid is held low
        int          err_burst;   // burst index answered with SLVERR, -1 for none
        int          abort_at;    // assert reset when this many beats have gone, -1 for none
        bit          poke;        // pulse wr_enb while W beats are flowing
        int          exp_beats;
        int          exp_bursts;
        bit          exp_err;
    } vec_t;

    task automatic check(input string name, input logic [255:0] got, input logic [255:0] exp);
        nchecks++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Reference beat payload straight from the packing rules.
    function automatic logic [255:0] exp_beat(input bit special, input int k);
        logic [255:0] w;
        w = '0;
        if (special) begin
            // four PEs per beat, low 64 bits each, PE 4k in the lowest lane
            for (int j = 0; j < 4; j++) w[j*64 +: 64] = regfiles[(4*k + j)*128 +: 64];
        end else begin
            w = regfiles[k*256 +: 256];
        end
        return w;
    endfunction

    task automatic run_xfer(input vec_t v);
        int          beats, bursts, b_seen, pend_b, cyc, blen;
        bit          special, final_b, poked, prev_aw_st, prev_w_st;
        logic [31:0] prev_awaddr, exp_addr;
        logic [7:0]  prev_awlen;
        logic [255:0] prev_wdata, hand;
        logic        prev_wlast;
        beats = 0; bursts = 0; b_seen = 0; pend_b = 0; cyc = 0;
        final_b = 0; poked = 0; prev_aw_st = 0; prev_w_st = 0;
        prev_awaddr = '0; prev_awlen = '0; prev_wdata = '0; prev_wlast = 1'b0;

        for (int i = 0; i < NB/32; i++) regfiles[i*32 +: 32] = $urandom;
        special = !v.mixed && (v.dt == FP16);

        mixed = v.mixed; addr_type.datatype = v.dt; base_addr = v.base;
        wr_enb = 1'b1;
        @(negedge clk);
        wr_enb = 1'b0;
        // scramble the mode inputs: the DUT must use what it latched at start
        mixed = 1'($urandom); addr_type.datatype = datatype_t'($urandom_range(3)); base_addr = $urandom;
        check("start_busy", busy, 1'b1);
        check("start_err_clear", err, 1'b0);

        while (1) begin
            if (v.abort_at >= 0 && beats == v.abort_at) begin
                check("abort_mid_burst", wvalid, 1'b1);
                rst = 1'b1;
                #1;
                check("abort_awvalid", awvalid, 1'b0);
                check("abort_wvalid", wvalid, 1'b0);
                check("abort_bready", bready, 1'b0);
                check("abort_wlast", wlast, 1'b0);
                check("abort_busy", busy, 1'b0);
                check("abort_done", done, 1'b0);
                check("abort_err", err, 1'b0);
                awready = 1'b0; wready = 1'b0; bvalid = 1'b0;
                @(negedge clk);
                rst = 1'b0;
                @(negedge clk);
                return;
            end
            if (final_b) begin
                check("done_pulse", done, 1'b1);
                check("err_at_done", err, v.exp_err);
                check("busy_at_done", busy, 1'b0);
                break;
            end
            check("no_early_done", done, 1'b0);
            if (prev_aw_st) begin
                check("aw_hold_valid", awvalid, 1'b1);
                check("aw_hold_addr", awaddr, prev_awaddr);
                check("aw_hold_len", awlen, prev_awlen);
            end
            if (prev_w_st) begin
                check("w_hold_valid", wvalid, 1'b1);
                check("w_hold_data", wdata, prev_wdata);
                check("w_hold_last", wlast, prev_wlast);
            end

            awready = ($urandom_range(99) >= 32'(v.stall));
            wready  = ($urandom_range(99) >= 32'(v.stall));
            bvalid  = (pend_b > 0) && (bvalid || ($urandom_range(99) >= 32'(v.stall)));
            bresp   = (b_seen == v.err_burst) ? 2'b10 : 2'b00;

            if (awvalid && awready) begin
                exp_addr = v.base + 32'(bursts * MB * (DW/8));
                blen = v.exp_beats - bursts * MB;
                if (blen > MB) blen = MB;
                check("awaddr", awaddr, exp_addr);
                check("awlen", awlen, 8'(blen - 1));
                bursts++;
            end
            if (wvalid && wready) begin
                if (beats < v.exp_beats) check("wdata", wdata, exp_beat(special, beats));
                else check("extra_beat", beats, v.exp_beats - 1);
                check("wlast", wlast, ((beats + 1) % MB == 0) || (beats + 1 == v.exp_beats));
                if (special && beats == 0) begin
                    hand = {regfiles[3*128 +: 64], regfiles[2*128 +: 64], regfiles[128 +: 64], regfiles[0 +: 64]};
                    check("special_beat0", wdata, hand);
                end
                if (wlast) pend_b++;
                beats++;
            end
            if (bready && bvalid) begin
                b_seen++;
                pend_b--;
                bvalid = 1'b0;
                if (b_seen == v.exp_bursts) final_b = 1;
                // keep handshake visible through the coming edge
                bvalid = 1'b1;
            end

            prev_aw_st = awvalid && !awready; prev_awaddr = awaddr; prev_awlen = awlen;
            prev_w_st  = wvalid && !wready;   prev_wdata  = wdata;  prev_wlast = wlast;

            if (v.poke && wvalid && !poked) begin
                wr_enb = 1'b1;
                poked  = 1;
            end else begin
                wr_enb = 1'b0;
            end

            cyc++;
            if (cyc > 4000) begin
                nchecks++; nerr++;
                $display("FAIL timeout: no done after %0d cycles, beats=%0d", cyc, beats);
                break;
            end
            @(negedge clk);
            if (bvalid && !bready) bvalid = 1'b1;
            else if (bvalid && b_seen > 0 && pend_b == 0) bvalid = 1'b0;
        end
        awready = 1'b0; wready = 1'b0; bvalid = 1'b0; wr_enb = 1'b0;
        @(negedge clk);
        check("beats_total", beats, v.exp_beats);
        check("bursts_total", bursts, v.exp_bursts);
        check("idle_after", busy | awvalid | wvalid, 1'b0);
    endtask

    vec_t vecs [9];
    vec_t rv;

    initial begin
        rst = 1'b1; wr_enb = 1'b0; mixed = 1'b0; addr_type.datatype = INT8; base_addr = '0;
        regfiles = '0; awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;

        vecs[0] = '{1'b0, INT8, 32'h1000,     0, -1, -1, 1'b0, 32, 2, 1'b0};
        vecs[1] = '{1'b0, FP16, 32'h2000,     0, -1, -1, 1'b0, 16, 1, 1'b0};
        vecs[2] = '{1'b1, FP16, 32'h40,      40, -1, -1, 1'b0, 32, 2, 1'b0};
        vecs[3] = '{1'b0, FP16, 32'h3000_0000, 50, -1, -1, 1'b0, 16, 1, 1'b0};
        vecs[4] = '{1'b0, FP32, 32'h8000,    30,  0, -1, 1'b0, 32, 2, 1'b1};
        vecs[5] = '{1'b1, INT8, 32'h8000,    30, -1, -1, 1'b0, 32, 2, 1'b0};
        vecs[6] = '{1'b0, BF16, 32'h100,     30, -1, -1, 1'b1, 32, 2, 1'b0};
        vecs[7] = '{1'b0, INT8, 32'h5000,     0, -1,  7, 1'b0, 32, 2, 1'b0};
        vecs[8] = '{1'b0, INT8, 32'h5000,    20, -1, -1, 1'b0, 32, 2, 1'b0};

        @(negedge clk);
        @(negedge clk);
        check("rst_awvalid", awvalid, 1'b0);
        check("rst_wvalid", wvalid, 1'b0);
        check("rst_bready", bready, 1'b0);
        check("rst_wlast", wlast, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_err", err, 1'b0);
        check("awsize", awsize, 3'd5);
        check("awburst", awburst, 2'b01);
        check("wstrb", wstrb, {32{1'b1}});
        rst = 1'b0;
        @(negedge clk);

        for (int n = 0; n < 9; n++) run_xfer(vecs[n]);

        for (int r = 0; r < 4; r++) begin
            rv.mixed      = 1'($urandom);
            rv.dt         = datatype_t'($urandom_range(3));
            rv.base       = $urandom;
            rv.stall      = int'($urandom_range(60));
            rv.err_burst  = int'($urandom_range(2)) - 1;
            rv.abort_at   = -1;
            rv.poke       = 1'($urandom);
            rv.exp_beats  = (!rv.mixed && rv.dt == FP16) ? 16 : 32;
            rv.exp_bursts = (rv.exp_beats + MB - 1) / MB;
            rv.exp_err    = (rv.err_burst >= 0) && (rv.err_burst < rv.exp_bursts);
            run_xfer(rv);
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchecks);
        $finish;
    end

endmodule

// File: doc/axi_tensor_wb.md
AXI_TENSOR_WB -- requirements
Module: axi_tensor_wb

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, AXI address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 256, AXI W beat width; multiple of 64.
REQ-003 SHALL have parameter PE_ROWS, default 8, PE array rows.
REQ-004 SHALL have parameter PE_COLS, default 8, PE array columns.
REQ-005 SHALL have parameter PE_WORD, default 128, bits per PE result; multiple of 128.
REQ-006 SHALL have parameter MAX_BURST, default 16, maximum beats per AW burst; 1..256.
REQ-007 SHALL have ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- wr_enb  in  1  start pulse.
- mixed  in  1  mixed-precision mode.
- addr_type  in  params::addrgen_t  datatype selector.
- base_addr  in  ADDR_WIDTH  byte start address.
- regfiles  in  PE_ROWS*PE_COLS*PE_WORD  PE results; PE i = row*PE_COLS+col at bits [i*PE_WORD +: PE_WORD].
- axi_awvalid / axi_awready  out / in  1  AW handshake.
- axi_awaddr  out  ADDR_WIDTH  burst address.
- axi_awlen  out  8  beats-1.
- axi_awsize  out  3  log2(DATA_WIDTH/8).
- axi_awburst  out  2  constant 2'b01.
- axi_wvalid / axi_wready  out / in  1  W handshake.
- axi_wdata  out  DATA_WIDTH  beat data.
- axi_wstrb  out  DATA_WIDTH/8  all ones.
- axi_wlast  out  1  last beat of burst.
- axi_bvalid  in  1  write response valid.
- axi_bready  out  1  write response ready.
- axi_bresp  in  2  write response code.
- busy  out  1  transfer in progress.
- done  out  1  one-cycle completion pulse.
- err  out  1  sticky: any non-OKAY bresp in last transfer.

Function
REQ-008 SHALL use special mode when mixed==0 and addr_type.datatype==params::FP16; normal mode otherwise; mode, base_addr latched at start.
REQ-009 Total beats SHALL be T = PE_ROWS*PE_COLS*PE_WORD/DATA_WIDTH (normal) or T/2 (special); defaults 32 / 16.
REQ-010 Normal beat k SHALL carry flat regfiles bits [k*DATA_WIDTH +: DATA_WIDTH].
REQ-011 Special beat k SHALL carry low PE_WORD/2 bits of consecutive PEs, ascending PE index in ascending lanes, starting at PE k*(2*DATA_WIDTH/PE_WORD).
REQ-012 FSM states IDLE, ADDR, DATA, RESP; IDLE->ADDR on wr_enb; ADDR->DATA on AW handshake; DATA->RESP on W handshake with wlast; RESP->ADDR on B handshake if beats remain, else RESP->IDLE.
REQ-013 Bursts SHALL be min(MAX_BURST, remaining) beats; awlen = burst-1; awaddr = base_addr + beats_sent*DATA_WIDTH/8.
REQ-014 awvalid SHALL be 1 exactly in ADDR; awaddr/awlen stable while awvalid && !awready.
REQ-015 wvalid SHALL be 1 exactly in DATA; wdata/wlast stable while wvalid && !wready; next beat presented the cycle after a handshake.
REQ-016 bready SHALL be 1 exactly in RESP.
REQ-017 busy SHALL be 0 only in IDLE; wr_enb while busy SHALL be ignored.
REQ-018 done SHALL pulse the cycle after the final B handshake; err updated the same cycle, cleared at next start.
REQ-019 regfiles SHALL be sampled combinationally; caller holds it stable while busy.
REQ-020 AW-to-first-W latency SHALL be one cycle after AW handshake.

Reset
REQ-021 rst SHALL force IDLE, clear counters, and drive awvalid, wvalid, bready, wlast, busy, done, err to 0 asynchronously, including mid-burst.
REQ-022 axi_awburst, axi_awsize, axi_wstrb SHALL be constants independent of reset.

Structure
REQ-023 addrgen_t and datatype enum SHALL come from params (para_pkg.sv); FSM state typedef is local.
REQ-024 Beat selection (REQ-010/011) SHALL be sub-module axi_wb_beat_sel (combinational: regfiles, mode, beat index -> wdata).

Verification
REQ-025 Normal mode, base 0x1000, always-ready slave -> bursts at 0x1000, 0x1200, awlen 15 each, 32 beats, wlast on beats 15/31, done 1 pulse.
REQ-026 Special mode (mixed=0, FP16) -> one burst awlen 15, 16 beats of packed low halves; beat 0 = PE0..PE3 low 64 bits.
REQ-027 Random wready/awready/bvalid stalls -> wdata/awaddr stable during stall; beat data matches model.
REQ-028 bresp=2'b10 on first burst -> second burst still issued; err=1 at done; next start clears err.
REQ-029 rst asserted at beat 7 -> all valids low immediately; new wr_enb restarts at beat 0.
REQ-030 wr_enb pulsed during DATA -> ignored; beat count unchanged.
